ws2812_frame_tx: RTL and testbench

//  Parametrised WS2812B serial transmitter for the LED matrix chain. Replaces the fixed
//  24-bit, single-pixel make_data_stream path: accepts a stream of pixels over a

---
 rtl/ws2812_frame_tx.sv | 138 +++++++++++++
 tb/tb_ws2812_frame_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_tx.sv
// ws2812_frame_tx: FIFO-buffered WS2812B pixel serialiser, MSB first, with a latch low period closing each frame.
module ws2812_frame_tx #(
    parameter int COLOR_BITS   = 24,
    parameter int DEPTH        = 8,
    parameter int BIT_CYCLES   = 50,
    parameter int T0H_CYCLES   = 16,
    parameter int T1H_CYCLES   = 32,
    parameter int LATCH_CYCLES = 2400
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_valid,
    input  logic [COLOR_BITS-1:0] pix_data,
    input  logic                  pix_last,
    output logic                  pix_ready,
    output logic                  dout,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  underrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(BIT_CYCLES > LATCH_CYCLES ? BIT_CYCLES : LATCH_CYCLES);
    localparam int BW = $clog2(COLOR_BITS);

    typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, LATCH} state_t;

    state_t state, state_n;
    logic [COLOR_BITS:0] mem [DEPTH];
    logic [COLOR_BITS:0] head;
    logic [AW:0] wr_ptr, rd_ptr;
    logic [COLOR_BITS-1:0] shreg, shreg_n;
    logic last_flag, last_flag_n;
    logic [BW-1:0] bit_idx, bit_idx_n;
    logic [CW-1:0] cyc, cyc_n, th;
    logic rdy_en, empty, full, push, pop, bit_end, last_bit;

    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pix_ready = rdy_en & ~full;
    assign push      = pix_valid & pix_ready;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign busy      = state != IDLE;
    assign th        = shreg[COLOR_BITS-1] ? CW'(T1H_CYCLES - 1) : CW'(T0H_CYCLES - 1);
    assign bit_end   = cyc == CW'(BIT_CYCLES - 1);
    assign last_bit  = bit_idx == BW'(COLOR_BITS - 1);

    always_ff @(posedge clk)
        if (push)
            mem[wr_ptr[AW-1:0]] <= {pix_last, pix_data};

    // pix_ready is held low through reset and rises one cycle after it ends
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cyc       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            last_flag <= 1'b0;
            dout      <= 1'b0;
        end else begin
            state     <= state_n;
            cyc       <= cyc_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            last_flag <= last_flag_n;
            dout      <= state_n == HIGH;
        end
    end

    // The final LOW cycle of a pixel pops the next one directly so pixels stay contiguous
    always_comb begin
        state_n     = state;
        cyc_n       = cyc;
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        last_flag_n = last_flag;
        pop         = 1'b0;
        frame_done  = 1'b0;
        underrun    = 1'b0;
        case (state)
            IDLE: state_n = empty ? IDLE : LOAD;
            LOAD: begin
                pop                    = 1'b1;
                {last_flag_n, shreg_n} = head;
                bit_idx_n              = '0;
                cyc_n                  = '0;
                state_n                = HIGH;
            end
            HIGH: begin
                cyc_n   = cyc + 1'b1;
                state_n = cyc == th ? LOW : HIGH;
            end
            LOW: begin
                if (!bit_end) begin
                    cyc_n = cyc + 1'b1;
                end else if (!last_bit) begin
                    shreg_n   = shreg << 1;
                    bit_idx_n = bit_idx + 1'b1;
                    cyc_n     = '0;
                    state_n   = HIGH;
                end else if (last_flag) begin
                    cyc_n   = '0;
                    state_n = LATCH;
                end else if (!empty) begin
                    pop                    = 1'b1;
                    {last_flag_n, shreg_n} = head;
                    bit_idx_n              = '0;
                    cyc_n                  = '0;
                    state_n                = HIGH;
                end else begin
                    underrun = 1'b1;
                    cyc_n    = '0;
                    state_n  = LATCH;
                end
            end
            LATCH: begin
                frame_done = cyc == CW'(LATCH_CYCLES - 1);
                cyc_n      = frame_done ? '0 : cyc + 1'b1;
                state_n    = frame_done ? IDLE : LATCH;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ws2812_frame_tx.sv
// tb_ws2812_frame_tx: decodes dout back into pixels and checks them, and the frame timing, against the pixels pushed.
module tb_ws2812_frame_tx;
    localparam int CB0 = 24, BC0 = 50, T00 = 16, T10 = 32, LC0 = 2400;
    localparam int CB1 = 32, BC1 = 20, T01 = 6, T11 = 13, LC1 = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst, pv, pl, rdy, dout, busy, fd, ur;
    logic [23:0] pd0;
    logic [31:0] pd1;

    ws2812_frame_tx #(.COLOR_BITS(CB0), .DEPTH(4), .BIT_CYCLES(BC0), .T0H_CYCLES(T00),
                      .T1H_CYCLES(T10), .LATCH_CYCLES(LC0)) u0 (
        .clk(clk), .reset(rst[0]), .pix_valid(pv[0]), .pix_data(pd0), .pix_last(pl[0]),
        .pix_ready(rdy[0]), .dout(dout[0]), .busy(busy[0]), .frame_done(fd[0]), .underrun(ur[0]));

    ws2812_frame_tx #(.COLOR_BITS(CB1), .DEPTH(8), .BIT_CYCLES(BC1), .T0H_CYCLES(T01),
                      .T1H_CYCLES(T11), .LATCH_CYCLES(LC1)) u1 (
        .clk(clk), .reset(rst[1]), .pix_valid(pv[1]), .pix_data(pd1), .pix_last(pl[1]),
        .pix_ready(rdy[1]), .dout(dout[1]), .busy(busy[1]), .frame_done(fd[1]), .underrun(ur[1]));

    int tests = 0, fails = 0;
    longint cnt = 0;
    int fd_cnt[2] = '{0, 0}, ur_cnt[2] = '{0, 0};
    longint fd_at[2] = '{0, 0}, ur_at[2] = '{0, 0};
    int fd_base, ur_base;

    logic [31:0] txq[$], rx_px[$];
    longint tpush[$], rx_starts[$];
    longint rx_t0, rx_tr;
    int rx_terr, rx_long;
    bit rx_to;

    typedef struct {
        int g;
        logic [31:0] px;
        logic [31:0] exp_px;
        int exp_long;
    } vec_t;
    vec_t tbl[7];

    always @(posedge clk) cnt <= cnt + 1;

    always @(negedge clk)
        for (int i = 0; i < 2; i++) begin
            if (fd[i] === 1'b1) begin
                fd_cnt[i] <= fd_cnt[i] + 1;
                fd_at[i]  <= cnt;
            end
            if (ur[i] === 1'b1) begin
                ur_cnt[i] <= ur_cnt[i] + 1;
                ur_at[i]  <= cnt;
            end
        end

    function automatic int cbits(input int g); return g != 0 ? CB1 : CB0; endfunction
    function automatic int bcyc(input int g);  return g != 0 ? BC1 : BC0; endfunction
    function automatic int t0h(input int g);   return g != 0 ? T01 : T00; endfunction
    function automatic int t1h(input int g);   return g != 0 ? T11 : T10; endfunction
    function automatic int lcyc(input int g);  return g != 0 ? LC1 : LC0; endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int g, input logic [31:0] d, input logic l);
        int k = 0;
        pv[g] = 1'b1;
        pl[g] = l;
        if (g == 0) pd0 = d[23:0]; else pd1 = d;
        while (rdy[g] !== 1'b1 && k < 6000) begin
            k++;
            @(negedge clk);
        end
        if (k >= 6000) chk("push_ready_timeout", rdy[g], 1);
        @(negedge clk);
        pv[g] = 1'b0;
        tpush.push_back(cnt);
    endtask

    task automatic send(input int g, input int n, input bit with_last, input int maxgap);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, maxgap)) @(negedge clk);
            push(g, txq[i], with_last && i == n - 1);
        end
    endtask

    task automatic get_bit(input int g, output int w, output int h);
        w = 0;
        h = 0;
        while (dout[g] !== 1'b1 && w < 6000) begin
            w++;
            @(negedge clk);
        end
        rx_tr = cnt;
        while (dout[g] === 1'b1 && h < 6000) begin
            h++;
            @(negedge clk);
        end
        if (w >= 6000 || h >= 6000) rx_to = 1'b1;
    endtask

    task automatic rx_frame(input int g, input int n);
        int w, h, hp;
        logic [31:0] px;
        rx_px.delete();
        rx_starts.delete();
        rx_terr = 0;
        rx_long = 0;
        rx_to = 1'b0;
        hp = 0;
        for (int p = 0; p < n; p++) begin
            px = '0;
            for (int b = 0; b < cbits(g); b++) begin
                get_bit(g, w, h);
                if (rx_to) begin
                    rx_terr++;
                    return;
                end
                if (b == 0) rx_starts.push_back(rx_tr);
                if (p == 0 && b == 0) rx_t0 = rx_tr;
                else if (hp + w != bcyc(g)) rx_terr++;
                if (h != t0h(g) && h != t1h(g)) rx_terr++;
                px = {px[30:0], h == t1h(g)};
                rx_long += int'(h == t1h(g));
                hp = h;
            end
            rx_px.push_back(px);
        end
    endtask

    task automatic wait_idle(input int g);
        int k = 0;
        while (busy[g] === 1'b1 && k < 8000) begin
            k++;
            @(negedge clk);
        end
        chk("idle_after_frame", busy[g], 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_frame(input int g, input int n, input bit with_last, input int maxgap);
        fd_base = fd_cnt[g];
        ur_base = ur_cnt[g];
        tpush.delete();
        fork
            send(g, n, with_last, maxgap);
            rx_frame(g, n);
        join
        wait_idle(g);
    endtask

    task automatic check_frame(input string tag, input int g, input int n, input int exp_ur);
        for (int i = 0; i < n; i++)
            chk({tag, "_pixel"}, i < rx_px.size() ? rx_px[i] : 32'hxxxxxxxx,
                g != 0 ? txq[i] : {8'h0, txq[i][23:0]});
        chk({tag, "_timing_errors"}, rx_terr, 0);
        chk({tag, "_frame_done_pulses"}, fd_cnt[g] - fd_base, 1);
        chk({tag, "_underrun_pulses"}, ur_cnt[g] - ur_base, exp_ur);
        chk({tag, "_frame_length"}, fd_at[g] - rx_t0, n * cbits(g) * bcyc(g) + lcyc(g) - 1);
        chk({tag, "_first_rise_latency"}, rx_t0 - tpush[0], 2);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        int w, h, k, nb;
        longint t_drop, t_up;
        tbl[0] = '{0, 32'h00800001, 32'h00800001, 2};
        tbl[1] = '{0, 32'h00000000, 32'h00000000, 0};
        tbl[2] = '{0, 32'h00A5C30F, 32'h00A5C30F, 12};
        tbl[3] = '{1, 32'hFFFF0000, 32'hFFFF0000, 16};
        tbl[4] = '{1, 32'h0000FFFF, 32'h0000FFFF, 16};
        tbl[5] = '{1, 32'h80000001, 32'h80000001, 2};
        tbl[6] = '{1, 32'h12345678, 32'h12345678, 13};
        rst = 2'b11;
        pv = '0;
        pl = '0;
        pd0 = '0;
        pd1 = '0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++)
            chk("reset_outputs", {rdy[g], dout[g], busy[g], fd[g], ur[g]}, 0);
        rst = 2'b00;
        @(negedge clk);
        chk("ready_after_reset", rdy, 2'b11);

        for (int i = 0; i < 7; i++) begin
            txq = '{tbl[i].px};
            run_frame(tbl[i].g, 1, 1'b1, 0);
            chk("tbl_pixel", rx_px.size() > 0 ? rx_px[0] : 32'hxxxxxxxx, tbl[i].exp_px);
            chk("tbl_long_pulses", rx_long, tbl[i].exp_long);
            check_frame("tbl", tbl[i].g, 1, 0);
        end

        txq.delete();
        repeat (3) txq.push_back($urandom & 32'hFFFFFF);
        run_frame(0, 3, 1'b1, 0);
        check_frame("three_px", 0, 3, 0);

        txq.delete();
        repeat (6) txq.push_back($urandom & 32'hFFFFFF);
        fd_base = fd_cnt[0];
        ur_base = ur_cnt[0];
        tpush.delete();
        t_drop = -1;
        t_up = -1;
        fork
            send(0, 6, 1'b1, 0);
            rx_frame(0, 6);
            begin : watch
                for (int j = 0; j < 12000 && t_up < 0; j++) begin
                    if (rdy[0] !== 1'b1 && t_drop < 0) t_drop = cnt;
                    else if (rdy[0] === 1'b1 && t_drop >= 0) t_up = cnt;
                    @(negedge clk);
                end
            end
        join
        wait_idle(0);
        nb = 0;
        foreach (tpush[i]) if (tpush[i] <= t_drop) nb++;
        chk("depth4_writes_before_full", nb, 5);
        chk("depth4_ready_rise", t_up, rx_starts.size() > 1 ? rx_starts[1] : -1);
        check_frame("depth4", 0, 6, 0);

        txq.delete();
        repeat (2) txq.push_back($urandom & 32'hFFFFFF);
        run_frame(0, 2, 1'b0, 0);
        check_frame("underrun", 0, 2, 1);
        chk("underrun_to_frame_done", fd_at[0] - ur_at[0], LC0);
        chk("underrun_position", ur_at[0] - rx_t0, 2 * CB0 * BC0 - 1);

        txq = '{32'h5A5A5A, 32'hFFFFFF};
        fd_base = fd_cnt[0];
        ur_base = ur_cnt[0];
        push(0, txq[0], 1'b0);
        push(0, txq[1], 1'b1);
        for (int b = 0; b < 10; b++) get_bit(0, w, h);
        k = 0;
        while (dout[0] !== 1'b1 && k < 200) begin
            k++;
            @(negedge clk);
        end
        chk("reset_in_high_dout_before", dout[0], 1);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("reset_in_high_dout", dout[0], 0);
        chk("reset_in_high_busy", busy[0], 0);
        chk("reset_in_high_ready", rdy[0], 0);
        rst[0] = 1'b0;
        repeat (20) @(negedge clk);
        chk("reset_fifo_empty_busy", busy[0], 0);
        chk("reset_fifo_empty_dout", dout[0], 0);
        chk("reset_ready_back", rdy[0], 1);
        chk("reset_no_frame_done", fd_cnt[0] - fd_base, 0);
        chk("reset_no_underrun", ur_cnt[0] - ur_base, 0);

        for (int f = 0; f < 6; f++) begin
            k = $urandom_range(1, 5);
            txq.delete();
            repeat (k) txq.push_back($urandom);
            run_frame(1, k, 1'b1, 3);
            check_frame("random", 1, k, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
